// File: rtl/sobel_pkg.sv
// rtl/sobel_pkg.sv - shared widths, pixel types and gradient helpers for the Sobel stream
// Ports: none (package).
package sobel_pkg;

  localparam int PIX_W      = 8;
  localparam int GRAD_W     = 11;
  localparam int MAG_W      = 12;
  localparam int DEF_IMG_W  = 640;
  localparam int DEF_IMG_H  = 480;
  localparam int DEF_THRESH = 128;

  typedef logic [PIX_W-1:0]         pixel_t;
  typedef logic signed [GRAD_W-1:0] grad_t;

  // One vertical slice of the 3x3 window: top is row y-2, bot is row y.
  typedef struct packed {
    pixel_t top;
    pixel_t mid;
    pixel_t bot;
  } column_t;

  // a + 2b + c; the worst case 1020 still fits a signed 11-bit value.
  function automatic grad_t weighted_sum(input pixel_t a, input pixel_t b, input pixel_t c);
    grad_t ea, eb, ec;
    ea = grad_t'({{(GRAD_W-PIX_W){1'b0}}, a});
    eb = grad_t'({{(GRAD_W-PIX_W){1'b0}}, b});
    ec = grad_t'({{(GRAD_W-PIX_W){1'b0}}, c});
    return ea + (eb <<< 1) + ec;
  endfunction

  // |g| never exceeds 1020, so negation cannot overflow.
  function automatic logic [MAG_W-1:0] abs_grad(input grad_t g);
    return (g < 0) ? MAG_W'(-g) : MAG_W'(g);
  endfunction

endpackage

// File: rtl/sobel_stream_if.sv
// rtl/sobel_stream_if.sv - Avalon-ST style pixel sink and RGB source bundle
// Sink:   in_data[7:0], in_valid, in_startofpacket, in_endofpacket -> in_ready
// Source: out_data[23:0], out_valid, out_startofpacket, out_endofpacket <- out_ready
// Modports: slave (filter side), master (producer/consumer side).
interface sobel_stream_if;
  import sobel_pkg::*;

  pixel_t               in_data;
  logic                 in_valid;
  logic                 in_startofpacket;
  logic                 in_endofpacket;
  logic                 in_ready;

  logic [3*PIX_W-1:0]   out_data;
  logic                 out_valid;
  logic                 out_startofpacket;
  logic                 out_endofpacket;
  logic                 out_ready;

  modport slave (
    input  in_data, in_valid, in_startofpacket, in_endofpacket, out_ready,
    output in_ready, out_data, out_valid, out_startofpacket, out_endofpacket
  );

  modport master (
    output in_data, in_valid, in_startofpacket, in_endofpacket, out_ready,
    input  in_ready, out_data, out_valid, out_startofpacket, out_endofpacket
  );

endinterface

// File: rtl/sobel_line_buffer.sv
// rtl/sobel_line_buffer.sv - two-line pixel history, read-before-write per column
// Ports: clk (rising edge), en (accepted beat), x (column), wr_data (current pixel),
//        row_m1 / row_m2 (registered pixels of rows y-1 / y-2 at column x).
module sobel_line_buffer
  import sobel_pkg::*;
#(
  parameter int  IMG_W = DEF_IMG_W,
  localparam int XW    = (IMG_W > 1) ? $clog2(IMG_W) : 1
) (
  input  logic          clk,
  input  logic          en,
  input  logic [XW-1:0] x,
  input  pixel_t        wr_data,
  output pixel_t        row_m1,
  output pixel_t        row_m2
);

  pixel_t line_m1 [IMG_W];
  pixel_t line_m2 [IMG_W];

  // No reset: stale contents only reach rows masked as border by the top.
  // The y-1 pixel slides down into the y-2 line as the new pixel replaces it.
  always_ff @(posedge clk) begin
    if (en) begin
      row_m1     <= line_m1[x];
      row_m2     <= line_m2[x];
      line_m1[x] <= wr_data;
      line_m2[x] <= line_m1[x];
    end
  end

endmodule

// File: rtl/sobel_stream.sv
// rtl/sobel_stream.sv - streaming 3x3 Sobel edge magnitude, greyscale in, grey RGB out
// Ports: clk_clk, reset_reset_n (async, active low), st (sobel_stream_if.slave).
// Build option: SOBEL_THRESH_EN turns the magnitude into a binary edge map against THRESH.
// Pipeline: stage 1 = line-buffer read + beat qualifiers, stage 2 = window + magnitude.
module sobel_stream
  import sobel_pkg::*;
#(
  parameter int IMG_W  = DEF_IMG_W,
  parameter int IMG_H  = DEF_IMG_H,
  parameter int THRESH = DEF_THRESH
) (
  input  logic           clk_clk,
  input  logic           reset_reset_n,
  sobel_stream_if.slave  st
);

  localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

  if (THRESH < 0 || THRESH > 256) begin : g_thresh_range
    $error("sobel_stream: THRESH must lie in 0..256");
  end

  logic          en;
  logic          accept;
  logic [XW-1:0] x_q, x_cur;
  logic [YW-1:0] y_q, y_cur;

  // The whole pipeline moves in lockstep with the output register.
  assign en          = !st.out_valid || st.out_ready;
  assign st.in_ready = en;
  assign accept      = st.in_valid && en;

  // Start-of-packet pins the current beat to (0,0) even mid-frame.
  assign x_cur = st.in_startofpacket ? '0 : x_q;
  assign y_cur = st.in_startofpacket ? '0 : y_q;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      x_q <= '0;
      y_q <= '0;
    end else if (accept) begin
      if (x_cur == X_LAST) begin
        x_q <= '0;
        y_q <= (y_cur == Y_LAST) ? '0 : y_cur + 1'b1;
      end else begin
        x_q <= x_cur + 1'b1;
        y_q <= y_cur;
      end
    end
  end

  pixel_t row_m1, row_m2;

  sobel_line_buffer #(.IMG_W(IMG_W)) u_line_buffer (
    .clk     (clk_clk),
    .en      (accept),
    .x       (x_cur),
    .wr_data (st.in_data),
    .row_m1  (row_m1),
    .row_m2  (row_m2)
  );

  // Stage 1: aligned with the line-buffer read data.
  logic   s1_valid, s1_border, s1_sop, s1_eop;
  pixel_t s1_pix;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      s1_valid  <= 1'b0;
      s1_border <= 1'b1;
      s1_sop    <= 1'b0;
      s1_eop    <= 1'b0;
      s1_pix    <= '0;
    end else if (en) begin
      s1_valid <= st.in_valid;
      if (st.in_valid) begin
        s1_pix    <= st.in_data;
        s1_border <= (x_cur < XW'(2)) || (y_cur < YW'(2));
        s1_sop    <= st.in_startofpacket;
        s1_eop    <= st.in_endofpacket;
      end
    end
  end

  // Window: c0 = column x-2, c1 = column x-1, c2 = column x (arriving now).
  column_t c0, c1, c2;
  assign c2 = '{top: row_m2, mid: row_m1, bot: s1_pix};

  grad_t            gx, gy;
  logic [MAG_W-1:0] mag_sum;
  pixel_t           mag_sat, mag;

  always_comb begin
    gx      = weighted_sum(c2.top, c2.mid, c2.bot) - weighted_sum(c0.top, c0.mid, c0.bot);
    gy      = weighted_sum(c0.bot, c1.bot, c2.bot) - weighted_sum(c0.top, c1.top, c2.top);
    mag_sum = abs_grad(gx) + abs_grad(gy);
    mag_sat = (mag_sum > MAG_W'(255)) ? 8'hFF : mag_sum[PIX_W-1:0];
`ifdef SOBEL_THRESH_EN
    mag     = (int'(mag_sat) >= THRESH) ? 8'hFF : 8'h00;
`else
    mag     = mag_sat;
`endif
    // Border beats see stale window/line data; force them dark.
    if (s1_border) mag = '0;
  end

  // Stage 2: output register; holds while the sink stalls.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      c0                   <= '0;
      c1                   <= '0;
      st.out_valid         <= 1'b0;
      st.out_data          <= '0;
      st.out_startofpacket <= 1'b0;
      st.out_endofpacket   <= 1'b0;
    end else if (en) begin
      st.out_valid <= s1_valid;
      if (s1_valid) begin
        c0                   <= c1;
        c1                   <= c2;
        st.out_data          <= {mag, mag, mag};
        st.out_startofpacket <= s1_sop;
        st.out_endofpacket   <= s1_eop;
      end
    end
  end

endmodule
